// File: rtl/cam_pkg.sv
// Shared constants and match-vector helpers for the CAM table.
// Helpers operate on a fixed MAX_DEPTH-wide vector; callers zero-extend
// their DEPTH-wide match vector, so DEPTH must not exceed MAX_DEPTH.
package cam_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 16;
    localparam int unsigned ADDR_WIDTH_DEF = 4;
    localparam int unsigned MAX_ADDR_WIDTH = 8;
    localparam int unsigned MAX_DEPTH      = 1 << MAX_ADDR_WIDTH;

    typedef struct packed {
        logic                      found;
        logic [MAX_ADDR_WIDTH-1:0] index;
    } lsi_t;

    // Lowest set bit index plus any-bit flag; index is 0 when nothing is set.
    function automatic lsi_t lowest_set_index(input logic [MAX_DEPTH-1:0] vec);
        lsi_t r;
        r.found = |vec;
        r.index = '0;
        for (int i = int'(MAX_DEPTH) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                r.index = MAX_ADDR_WIDTH'(i);
            end
        end
        return r;
    endfunction

    // Clearing the lowest set bit leaves something only if two or more were set.
    function automatic logic at_least_two(input logic [MAX_DEPTH-1:0] vec);
        return (vec & (vec - MAX_DEPTH'(1))) != '0;
    endfunction

endpackage

// File: rtl/cam_table_if.sv
// Write / flush / search / result bundle of the CAM table.
// master: lookup producer or control logic; slave: the CAM.
//   wr_en, wr_addr, wr_data, wr_valid : entry store / invalidate
//   flush                              : clear all valid bits
//   search_en, search_key              : launch a lookup
//   result_valid, hit, hit_addr, multi_hit : lookup result, 2 cycles later
interface cam_table_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_valid;
    logic                  flush;
    logic                  search_en;
    logic [DATA_WIDTH-1:0] search_key;
    logic                  result_valid;
    logic                  hit;
    logic [ADDR_WIDTH-1:0] hit_addr;
    logic                  multi_hit;

    modport master (
        output wr_en, wr_addr, wr_data, wr_valid, flush, search_en, search_key,
        input  result_valid, hit, hit_addr, multi_hit
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_valid, flush, search_en, search_key,
        output result_valid, hit, hit_addr, multi_hit
    );
endinterface

// File: rtl/cam_priority_enc.sv
// Combinational match-vector encoder: any-hit, lowest matching index, multi-hit.
// Ports: match (DEPTH) in; hit_c, hit_addr_c (ADDR_WIDTH), multi_hit_c out.
module cam_priority_enc
    import cam_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic [DEPTH-1:0]      match,
    output logic                  hit_c,
    output logic [ADDR_WIDTH-1:0] hit_addr_c,
    output logic                  multi_hit_c
);

    logic [MAX_DEPTH-1:0] match_ext;
    lsi_t                 lsi;

    always_comb begin
        match_ext   = MAX_DEPTH'(match);
        lsi         = lowest_set_index(match_ext);
        hit_c       = lsi.found;
        hit_addr_c  = ADDR_WIDTH'(lsi.index);
        multi_hit_c = at_least_two(match_ext);
    end

endmodule

// File: rtl/cam_table.sv
// Writable CAM: DEPTH keys with valid bits, 2-stage pipelined search
// returning the lowest matching index and a multi-hit flag.
// Ports: clk, reset (async, active-high), bus (cam_table_if.slave).
module cam_table
    import cam_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DEPTH      = (1 << ADDR_WIDTH)
) (
    input  logic        clk,
    input  logic        reset,
    cam_table_if.slave  bus
);

    logic [DATA_WIDTH-1:0] key_q [DEPTH];
    logic [DEPTH-1:0]      valid_q;
    logic [DEPTH-1:0]      match_c;
    logic [DEPTH-1:0]      match_q;
    logic                  s1_valid_q;
    logic                  hit_c;
    logic [ADDR_WIDTH-1:0] hit_addr_c;
    logic                  multi_hit_c;
    logic                  result_valid_q;
    logic                  hit_q;
    logic [ADDR_WIDTH-1:0] hit_addr_q;
    logic                  multi_hit_q;

    // Key storage is not reset; it is written even when a flush clears valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (bus.wr_en && bus.wr_valid && bus.wr_addr == ADDR_WIDTH'(i)) begin
                key_q[i] <= bus.wr_data;
            end
        end
    end

    // Valid bits: flush overrides a same-cycle write; addresses >= DEPTH never decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (bus.flush) begin
            valid_q <= '0;
        end else if (bus.wr_en) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (bus.wr_addr == ADDR_WIDTH'(i)) begin
                    valid_q[i] <= bus.wr_valid;
                end
            end
        end
    end

    // Stage 1 compare against pre-edge table contents.
    always_comb begin
        match_c = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            match_c[i] = valid_q[i] && (key_q[i] == bus.search_key);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            match_q    <= '0;
        end else begin
            s1_valid_q <= bus.search_en;
            match_q    <= bus.search_en ? match_c : '0;
        end
    end

    cam_priority_enc #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_enc (
        .match       (match_q),
        .hit_c       (hit_c),
        .hit_addr_c  (hit_addr_c),
        .multi_hit_c (multi_hit_c)
    );

    // Stage 2 result register; fields forced to 0 when no result is presented.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_valid_q <= 1'b0;
            hit_q          <= 1'b0;
            hit_addr_q     <= '0;
            multi_hit_q    <= 1'b0;
        end else begin
            result_valid_q <= s1_valid_q;
            hit_q          <= s1_valid_q & hit_c;
            hit_addr_q     <= s1_valid_q ? hit_addr_c : '0;
            multi_hit_q    <= s1_valid_q & multi_hit_c;
        end
    end

    assign bus.result_valid = result_valid_q;
    assign bus.hit          = hit_q;
    assign bus.hit_addr     = hit_addr_q;
    assign bus.multi_hit    = multi_hit_q;

endmodule
